// File: rtl/tomasulo_pkg.sv
// Shared ROB geometry and entry layout for the tomasulo core.
// Pure declarations; no logic, no latency.
package tomasulo_pkg;
    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 3;
    localparam int REG_AW    = 4;
    localparam int DATA_W    = 16;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic              has_dest;
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrapping ROB pointer: +1 per cycle when inc, zeroed by rst or clr; 1-cycle update.
// No backpressure; the caller gates inc.
module rob_ptr_ctr #(
    parameter int W = 3
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk1) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end
endmodule

// File: rtl/rob_commit_unit.sv
// ROB with out-of-order CDB completion and in-order single retire per cycle; CDB->commit 2 edges.
// Issue stalls on alloc_ready (full or reset); optional flush port under ROB_FLUSH_EN.
module rob_commit_unit
    import tomasulo_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              alloc_valid,
    input  logic              alloc_has_dest,
    input  logic [REG_AW-1:0] alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [REG_AW-1:0] commit_reg,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W-1:0]  head_p,
    output logic [TAG_W-1:0]  tail_p,
    output logic [TAG_W:0]    rob_count,
    output logic              rob_empty,
    output logic              rob_full
);
    rob_entry_t rob_q [ROB_DEPTH];
    rob_entry_t head_e;
    logic       flush_i;
    logic       do_alloc;
    logic       do_commit;
    logic       cdb_hit;

`ifdef ROB_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign head_e      = rob_q[head_p];
    assign rob_full    = (rob_count == (TAG_W+1)'(ROB_DEPTH));
    assign rob_empty   = (rob_count == '0);
    assign alloc_ready = !rob_full && !rst;
    assign alloc_tag   = tail_p;

    // Full/empty come from rob_count since head_p == tail_p in both cases.
    assign do_alloc  = alloc_valid && alloc_ready && !flush_i;
    assign do_commit = head_e.busy && head_e.ready && !flush_i;
    // A same-cycle alloc to cdb_tag sees busy=0 here, so that writeback is dropped.
    assign cdb_hit   = cdb_valid && rob_q[cdb_tag].busy && !rob_q[cdb_tag].ready && !flush_i;

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            rob_count    <= '0;
            commit_valid <= 1'b0;
            commit_we    <= 1'b0;
            commit_reg   <= '0;
            commit_data  <= '0;
            commit_tag   <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            rob_count    <= '0;
            commit_valid <= 1'b0;
            commit_we    <= 1'b0;
        end else begin
            if (do_alloc) begin
                rob_q[tail_p] <= rob_entry_t'{busy: 1'b1, ready: 1'b0,
                                              has_dest: alloc_has_dest,
                                              dest: alloc_dest, value: '0};
            end
            if (cdb_hit) begin
                rob_q[cdb_tag].value <= cdb_data;
                rob_q[cdb_tag].ready <= 1'b1;
            end
            if (do_commit) begin
                rob_q[head_p].busy  <= 1'b0;
                rob_q[head_p].ready <= 1'b0;
                commit_reg          <= head_e.dest;
                commit_data         <= head_e.value;
                commit_tag          <= head_p;
            end
            commit_valid <= do_commit;
            commit_we    <= do_commit && head_e.has_dest;
            rob_count    <= rob_count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
        end
    end

    rob_ptr_ctr #(.W(TAG_W)) u_head (
        .clk1 (clk1),
        .rst  (rst),
        .clr  (flush_i),
        .inc  (do_commit),
        .ptr  (head_p)
    );

    rob_ptr_ctr #(.W(TAG_W)) u_tail (
        .clk1 (clk1),
        .rst  (rst),
        .clr  (flush_i),
        .inc  (do_alloc),
        .ptr  (tail_p)
    );
endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboarded bench for rob_commit_unit against a program-order queue model.
module tb_rob_commit_unit;
    import tomasulo_pkg::*;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              alloc_valid = 1'b0;
    logic              alloc_has_dest = 1'b0;
    logic [REG_AW-1:0] alloc_dest = '0;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              commit_valid, commit_we;
    logic [REG_AW-1:0] commit_reg;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag, head_p, tail_p;
    logic [TAG_W:0]    rob_count;
    logic              rob_empty, rob_full;

    always #5 clk1 = ~clk1;

    rob_commit_unit dut (
        .clk1           (clk1),
        .rst            (rst),
`ifdef ROB_FLUSH_EN
        .flush          (flush),
`endif
        .alloc_valid    (alloc_valid),
        .alloc_has_dest (alloc_has_dest),
        .alloc_dest     (alloc_dest),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .commit_valid   (commit_valid),
        .commit_we      (commit_we),
        .commit_reg     (commit_reg),
        .commit_data    (commit_data),
        .commit_tag     (commit_tag),
        .head_p         (head_p),
        .tail_p         (tail_p),
        .rob_count      (rob_count),
        .rob_empty      (rob_empty),
        .rob_full       (rob_full)
    );

    // Reference model: in-flight instructions in program order.
    typedef struct {
        int          tag;
        int          dest;
        bit          hd;
        bit          rdy;
        int          val;
    } rec_t;
    typedef struct {
        int we;
        int r;
        int d;
        int t;
    } cmt_t;

    rec_t mq[$];
    cmt_t eq[$];
    int   m_head = 0;
    int   m_tail = 0;
    int   last_reg = 0, last_data = 0, last_tag = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Applies one clock edge of architectural rules to the model.
    task automatic model_update();
        bit dc, al;
        if (rst) begin
            mq.delete(); eq.delete();
            m_head = 0; m_tail = 0;
            last_reg = 0; last_data = 0; last_tag = 0;
            return;
        end
`ifdef ROB_FLUSH_EN
        if (flush) begin
            mq.delete();
            m_head = 0; m_tail = 0;
            return;
        end
`endif
        dc = (mq.size() > 0) && mq[0].rdy;
        al = alloc_valid && (mq.size() < ROB_DEPTH);
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(cdb_tag) && !mq[i].rdy) begin
                    mq[i].rdy = 1'b1;
                    mq[i].val = int'(cdb_data);
                end
            end
        end
        if (dc) begin
            eq.push_back('{we: int'(mq[0].hd), r: mq[0].dest, d: mq[0].val, t: mq[0].tag});
            void'(mq.pop_front());
            m_head = (m_head + 1) % ROB_DEPTH;
        end
        if (al) begin
            mq.push_back('{tag: m_tail, dest: int'(alloc_dest), hd: alloc_has_dest, rdy: 1'b0, val: 0});
            m_tail = (m_tail + 1) % ROB_DEPTH;
        end
    endtask

    task automatic check_state();
        chk("rob_count", rob_count, mq.size());
        chk("head_p", head_p, m_head);
        chk("tail_p", tail_p, m_tail);
        chk("alloc_ready", alloc_ready, (!rst && mq.size() < ROB_DEPTH));
        chk("rob_full", rob_full, mq.size() == ROB_DEPTH);
        chk("rob_empty", rob_empty, mq.size() == 0);
    endtask

    task automatic step(input logic a, input logic h, input logic [REG_AW-1:0] d,
                        input logic c, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        alloc_valid = a; alloc_has_dest = h; alloc_dest = d;
        cdb_valid = c; cdb_tag = t; cdb_data = v;
        @(posedge clk1);
        model_update();
        @(negedge clk1);
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    // Monitor: every commit pulse must match the model's next retirement.
    always @(negedge clk1) begin
        cmt_t e;
        if (commit_valid) begin
            if (eq.size() == 0) begin
                chk("unexpected_commit", commit_valid, 0);
            end else begin
                e = eq.pop_front();
                chk("commit_we", commit_we, e.we);
                chk("commit_reg", commit_reg, e.r);
                chk("commit_data", commit_data, e.d);
                chk("commit_tag", commit_tag, e.t);
                last_reg = e.r; last_data = e.d; last_tag = e.t;
            end
        end else begin
            chk("missing_commit", eq.size(), 0);
            chk("commit_we_idle", commit_we, 0);
            chk("commit_reg_hold", commit_reg, last_reg);
            chk("commit_data_hold", commit_data, last_data);
            chk("commit_tag_hold", commit_tag, last_tag);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles, then release.
        rst = 1'b1;
        idle(2);
        chk("rst_commit_valid", commit_valid, 0);
        rst = 1'b0;
        #1;
        chk("alloc_ready_after_rst", alloc_ready, 1);

        // Out-of-order completion, in-order retirement.
        step(1, 1, 4'd1, 0, 0, 0);
        step(1, 1, 4'd2, 0, 0, 0);
        step(1, 1, 4'd3, 0, 0, 0);
        step(0, 0, 0, 1, 3'd2, 16'h0033);
        step(0, 0, 0, 1, 3'd0, 16'h0011);
        step(0, 0, 0, 1, 3'd1, 16'h0022);
        idle(4);

        // Fill to full, overflow request ignored, free one slot.
        rst = 1'b1; idle(1); rst = 1'b0;
        for (int i = 0; i < ROB_DEPTH; i++) step(1, 1, REG_AW'(i + 4), 0, 0, 0);
        chk("full_flag", rob_full, 1);
        step(1, 1, 4'd15, 0, 0, 0);
        chk("full_tail_wrap", tail_p, 0);
        step(0, 0, 0, 1, 3'd0, 16'h0abc);
        step(1, 1, 4'd9, 0, 0, 0);
        idle(1);
        for (int i = 1; i < ROB_DEPTH; i++) step(0, 0, 0, 1, TAG_W'(i), DATA_W'($urandom));
        idle(3);

        // Alloc/CDB/commit triples wrapping the pointers.
        for (int i = 0; i < 20; i++) begin
            logic [TAG_W-1:0] t;
            t = tail_p;
            step(1, 1, REG_AW'(i), 0, 0, 0);
            step(0, 0, 0, 1, t, DATA_W'($urandom));
            idle(1);
        end
        idle(2);

        // No-destination instruction, then writeback to an idle tag.
        begin
            logic [TAG_W-1:0] t;
            t = tail_p;
            step(1, 0, 4'd7, 0, 0, 0);
            step(0, 0, 0, 1, t, 16'h5555);
            idle(2);
            step(0, 0, 0, 1, t + 3'd3, 16'h6666);
            idle(2);
        end

        // Randomized traffic with occasional mid-flight reset.
        for (int n = 0; n < 600; n++) begin
            logic a, h, c;
            logic [TAG_W-1:0] t;
            a = ($urandom_range(0, 99) < 55);
            h = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) < 60);
            t = TAG_W'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 99) < 70)
                t = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else if (a && $urandom_range(0, 1) == 1)
                t = tail_p;
            if (n % 150 == 149 && mq.size() > 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
            step(a, h, REG_AW'($urandom), c, t, DATA_W'($urandom));
        end

`ifdef ROB_FLUSH_EN
        rst = 1'b1; idle(1); rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 1, REG_AW'(i), 0, 0, 0);
        step(0, 0, 0, 1, 3'd3, 16'h0303);
        step(0, 0, 0, 1, 3'd4, 16'h0404);
        flush = 1'b1;
        step(1, 1, 4'd9, 1, 3'd0, 16'h0909);
        flush = 1'b0;
        chk("flush_count", rob_count, 0);
        chk("flush_tail", tail_p, 0);
        idle(3);
`endif

        // Drain whatever remains and confirm the scoreboard empties.
        while (mq.size() > 0) begin
            int k;
            k = -1;
            foreach (mq[i]) if (!mq[i].rdy && k < 0) k = i;
            if (k < 0) idle(1);
            else step(0, 0, 0, 1, TAG_W'(mq[k].tag), DATA_W'($urandom));
        end
        idle(3);
        chk("final_scoreboard_empty", eq.size(), 0);
        chk("final_empty", rob_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
